// File: rtl/neu_serial_mac.sv
// neu_serial_mac: serial FP32 neuron, h = act(bias + sum x[i]*w[i]), one shared multiply and add per cycle
`timescale 1ns/1ps
module neu_serial_mac #(
    parameter int N_IN  = 3,
    parameter int CNT_W = $clog2(N_IN) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*N_IN-1:0]   x_flat,
    input  logic [32*N_IN-1:0]   w_flat,
    input  logic [31:0]          bias,
    input  logic [1:0]           act_mode,
    input  logic                 z_read,
    input  logic                 h_read,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out,
    output logic [31:0]          z_backout,
    output logic [31:0]          h_backout
);

    localparam logic [31:0] QNAN   = 32'h7FC00000;
    localparam logic [31:0] ONE    = 32'h3F800000;
    localparam logic [31:0] EIGHTH = 32'h3E000000;

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [N_IN-1:0][31:0]   x_q, x_d, w_q, w_d;
    logic [1:0]              mode_q, mode_d;
    logic [31:0]             acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             out_q, out_d, zb_q, zb_d, hb_q, hb_d;
    logic [31:0]             xs, ws, prod, sum, h, deriv, relu, leaky;
    logic                    z_nan, z_pos;

    // Round-to-nearest-even on a 24-bit mantissa with hidden bit; a wrapped mantissa means carry-out.
    // Overflow saturates to inf, anything below the normal range flushes to signed zero.
    function automatic logic [31:0] fp_round(input logic s, input logic signed [9:0] e,
                                             input logic [23:0] m, input logic g, input logic st);
        logic [23:0]        r;
        logic signed [9:0]  er;
        r  = m + {23'd0, g & (st | m[0])};
        er = e + (r[23] ? 10'sd0 : 10'sd1);
        if (er >= 10'sd255) return {s, 8'hFF, 23'd0};
        if (er <= 10'sd0) return {s, 31'd0};
        return {s, er[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s, an, bn, ai, bi, az, bz;
        logic [47:0]        p;
        logic signed [9:0]  e;
        s  = a[31] ^ b[31];
        an = (&a[30:23]) & (|a[22:0]);
        bn = (&b[30:23]) & (|b[22:0]);
        ai = (&a[30:23]) & ~(|a[22:0]);
        bi = (&b[30:23]) & ~(|b[22:0]);
        az = a[30:23] == 8'd0;
        bz = b[30:23] == 8'd0;
        if (an | bn | (ai & bz) | (bi & az)) return QNAN;
        if (ai | bi) return {s, 8'hFF, 23'd0};
        if (az | bz) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127 + (p[47] ? 10'sd1 : 10'sd0);
        return p[47] ? fp_round(s, e, p[47:24], p[23], |p[22:0])
                     : fp_round(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               an, bn, ai, bi, az, bz, sw, sg;
        logic [30:0]        big, sml;
        logic [7:0]         d;
        logic [4:0]         dc, lz;
        logic [26:0]        ma, mb, bs, df, mm;
        logic [53:0]        t;
        logic [27:0]        s28;
        logic signed [9:0]  e;
        an = (&a[30:23]) & (|a[22:0]);
        bn = (&b[30:23]) & (|b[22:0]);
        ai = (&a[30:23]) & ~(|a[22:0]);
        bi = (&b[30:23]) & ~(|b[22:0]);
        az = a[30:23] == 8'd0;
        bz = b[30:23] == 8'd0;
        if (an | bn | (ai & bi & (a[31] ^ b[31]))) return QNAN;
        if (ai) return a;
        if (bi) return b;
        if (az & bz) return {a[31] & b[31], 31'd0};
        if (az) return b;
        if (bz) return a;
        sw  = b[30:0] > a[30:0];
        big = sw ? b[30:0] : a[30:0];
        sml = sw ? a[30:0] : b[30:0];
        sg  = sw ? b[31] : a[31];
        d   = big[30:23] - sml[30:23];
        dc  = (d > 8'd27) ? 5'd27 : d[4:0];
        ma  = {1'b1, big[22:0], 3'b000};
        mb  = {1'b1, sml[22:0], 3'b000};
        t   = {mb, 27'd0} >> dc;
        bs  = t[53:27] | {26'd0, |t[26:0]};
        e   = $signed({2'b0, big[30:23]});
        if (a[31] == b[31]) begin
            s28 = {1'b0, ma} + {1'b0, bs};
            mm  = s28[27] ? (s28[27:1] | {26'd0, s28[0]}) : s28[26:0];
            e   = e + (s28[27] ? 10'sd1 : 10'sd0);
        end else begin
            df = ma - bs;
            if (df == 27'd0) return 32'd0;
            lz = 5'd0;
            for (int i = 0; i < 27; i++) if (df[i]) lz = 5'(26 - i);
            mm = df << lz;
            e  = e - $signed({5'd0, lz});
        end
        return fp_round(sg, e, mm[26:3], mm[2], |mm[1:0]);
    endfunction

    // Select the operand pair for the current term.
    always_comb begin
        xs = 32'd0;
        ws = 32'd0;
        for (int i = 0; i < N_IN; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                xs = x_q[i];
                ws = w_q[i];
            end
        end
    end

    assign prod = fp_mul(xs, ws);
    assign sum  = fp_add(acc_q, prod);

    // Activation and its derivative, evaluated on the finished accumulator.
    always_comb begin
        z_nan = (&acc_q[30:23]) & (|acc_q[22:0]);
        z_pos = ~acc_q[31] & (|acc_q[30:0]);
        relu  = acc_q[31] ? 32'd0 : acc_q;
        leaky = (z_nan | ~acc_q[31]) ? acc_q :
                (acc_q[30:23] <= 8'd3) ? {1'b1, 31'd0} : {1'b1, acc_q[30:23] - 8'd3, acc_q[22:0]};
        h     = (mode_q == 2'd1) ? relu : (mode_q == 2'd2) ? leaky : acc_q;
        deriv = (z_pos | (mode_q == 2'd0) | (mode_q == 2'd3)) ? ONE : (mode_q == 2'd1) ? 32'd0 : EIGHTH;
    end

    // Next-state and datapath updates for IDLE -> MAC -> ACT -> DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        w_d     = w_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        zb_d    = zb_q;
        hb_d    = hb_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_flat;
                    w_d     = w_flat;
                    mode_d  = act_mode;
                    acc_d   = bias;
                    cnt_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d   = sum;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(N_IN - 1)) ? ACT : MAC;
            end
            ACT: begin
                out_d   = h;
                zb_d    = z_read ? acc_q : zb_q;
                hb_d    = h_read ? deriv : hb_q;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            w_q     <= '0;
            mode_q  <= 2'd0;
            acc_q   <= 32'd0;
            cnt_q   <= '0;
            out_q   <= 32'd0;
            zb_q    <= 32'd0;
            hb_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            w_q     <= w_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            zb_q    <= zb_d;
            hb_q    <= hb_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out       = out_q;
    assign z_backout = zb_q;
    assign h_backout = hb_q;

endmodule

// File: tb/tb_neu_serial_mac.sv
// tb_neu_serial_mac: directed scoreboard bench for the serial FP32 neuron
`timescale 1ns/1ps
module tb_neu_serial_mac;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, z_read, h_read, out_valid, out_ready;
    logic [95:0]  x_flat, w_flat;
    logic [31:0]  bias, out, z_backout, h_backout;
    logic [1:0]   act_mode;

    typedef struct packed {
        logic [31:0] o;
        logic [31:0] z;
        logic [31:0] h;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] zb_m, hb_m;
    int          tests = 0;
    int          fails = 0;

    neu_serial_mac #(.N_IN(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .w_flat(w_flat), .bias(bias), .act_mode(act_mode),
        .z_read(z_read), .h_read(h_read), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .z_backout(z_backout), .h_backout(h_backout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] x0, x1, x2, w0, w1, w2, b, input logic [1:0] m,
                          input logic zr, hr, input logic [31:0] eo, ez, eh, input int hold);
        exp_t e;
        int   k;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        x_flat   = {x2, x1, x0};
        w_flat   = {w2, w1, w0};
        bias     = b;
        act_mode = m;
        z_read   = zr;
        h_read   = hr;
        in_valid = 1'b1;
        if (zr) zb_m = ez;
        if (hr) hb_m = eh;
        e.o = eo;
        e.z = zb_m;
        e.h = hb_m;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        x_flat   = {$urandom, $urandom, $urandom};
        w_flat   = {$urandom, $urandom, $urandom};
        bias     = $urandom;
        act_mode = ~m;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, 32'd4);
        check("out_valid_rise", {31'd0, out_valid}, 32'd1);
        if (!out_valid) begin
            void'(sb.pop_front());
            return;
        end
        if (hold > 0) in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out", out, eo);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        check("out", out, e.o);
        check("z_backout", z_backout, e.z);
        check("h_backout", h_backout, e.h);
        @(negedge clk);
        out_ready = 1'b0;
        check("no_dup_valid", {31'd0, out_valid}, 32'd0);
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; z_read = 1'b0; h_read = 1'b0;
        x_flat = '0; w_flat = '0; bias = '0; act_mode = 2'd0;
        zb_m = 32'd0; hb_m = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_out", out, 32'd0);
        check("rst_zb", z_backout, 32'd0);
        check("rst_hb", h_backout, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
               32'h0, 2'd1, 1'b1, 1'b1, 32'h40400000, 32'h40400000, 32'h3F800000, 0);
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF000000, 32'hBF000000, 32'hBF000000,
               32'h0, 2'd1, 1'b1, 1'b1, 32'h00000000, 32'hC0400000, 32'h00000000, 0);
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF000000, 32'hBF000000, 32'hBF000000,
               32'h0, 2'd2, 1'b1, 1'b1, 32'hBEC00000, 32'hC0400000, 32'h3E000000, 10);
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
               32'h0, 2'd0, 1'b0, 1'b0, 32'h40400000, 32'h0, 32'h0, 0);
        @(negedge clk);
        x_flat = {32'h40400000, 32'h40000000, 32'h3F800000};
        w_flat = {3{32'h3F000000}};
        bias = 32'h0; act_mode = 2'd0; z_read = 1'b1; h_read = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out", out, 32'd0);
        check("midrst_zb", z_backout, 32'd0);
        check("midrst_hb", h_backout, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        zb_m = 32'd0; hb_m = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
               32'h0, 2'd0, 1'b1, 1'b1, 32'h40400000, 32'h40400000, 32'h3F800000, 0);
        run_op(32'h7F800000, 32'h40000000, 32'h40400000, 32'h00000000, 32'h3F000000, 32'h3F000000,
               32'h0, 2'd0, 1'b1, 1'b1, 32'h7FC00000, 32'h7FC00000, 32'h3F800000, 0);
        run_op(32'h7F7FFFFF, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0,
               32'h7F7FFFFF, 2'd0, 1'b1, 1'b1, 32'h7F800000, 32'h7F800000, 32'h3F800000, 0);
        run_op(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h80000000, 2'd1, 1'b1, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 0);
        run_op(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h81000000, 2'd2, 1'b1, 1'b1, 32'h80000000, 32'h81000000, 32'h3E000000, 0);
        run_op(32'h3F800001, 32'h0, 32'h0, 32'h3F800001, 32'h0, 32'h0,
               32'h0, 2'd0, 1'b1, 1'b1, 32'h3F800002, 32'h3F800002, 32'h3F800000, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
